pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning the address loaded on reset.
REQ-003 SHALL have parameter INC, default 4, meaning the sequential increment; it must be a power of two.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning the return-address stack entry count, at least 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst as elsewhere in the codebase.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-009 SHALL have port mode, input, 3 bits: next-address select.
REQ-010 SHALL have port target, input, WIDTH bits: absolute address for JUMP and CALL.
REQ-011 SHALL have port offset, input, WIDTH bits: two's-complement displacement for BRANCH.
REQ-012 SHALL have port currentAddress, output, WIDTH bits: registered PC value.
REQ-013 SHALL have port rasCount, output, $clog2(RAS_DEPTH+1) bits: number of valid stack entries.
REQ-014 SHALL have port rasOverflow, output, 1 bit: sticky flag, set when a CALL is made while the stack is full.
REQ-015 SHALL have port rasUnderflow, output, 1 bit: sticky flag, set when a RET is made while the stack is empty.
REQ-016 SHALL have port misaligned, output, 1 bit: combinational; high when currentAddress modulo INC is nonzero.

Function
REQ-017 SHALL update currentAddress only on the rising clk edge, so the new PC is visible one cycle after mode, target and offset are sampled.
REQ-018 SHALL load currentAddress with currentAddress+INC for mode 0 (SEQ).
REQ-019 SHALL load currentAddress with currentAddress+offset for mode 1 (BRANCH), with offset sign-interpreted.
REQ-020 SHALL load currentAddress with target for mode 2 (JUMP).
REQ-021 SHALL, for mode 3 (CALL), push currentAddress+INC onto the stack and load currentAddress with target in the same edge.
REQ-022 SHALL, for mode 4 (RET) with rasCount>0, pop the top entry into currentAddress and decrement rasCount.
REQ-023 SHALL treat mode values 5–7 as SEQ.
REQ-024 SHALL compute all address arithmetic modulo 2^WIDTH, with silent wrap-around and no carry output.
REQ-025 SHALL, on CALL with rasCount==RAS_DEPTH, overwrite the oldest entry (circular stack), keep rasCount at RAS_DEPTH, set rasOverflow, and still load target.
REQ-026 SHALL, on RET with rasCount==0, load currentAddress+INC, leave rasCount at 0, and set rasUnderflow.
REQ-027 SHALL, when stall=1, hold currentAddress, the stack contents, rasCount and both flags, regardless of mode.
REQ-028 SHALL keep rasOverflow and rasUnderflow set until rst.
REQ-029 SHALL return the most recent surviving pushes in LIFO order when a RET follows one or more overflows.

Reset
REQ-030 SHALL, when rst=1 at a clk edge, set currentAddress=RESET_VECTOR, rasCount=0, rasOverflow=0 and rasUnderflow=0.
REQ-031 SHALL give rst priority over stall and over every mode, including a reset asserted mid-CALL or mid-RET.
REQ-032 SHALL treat stack contents as don't-care after reset; only rasCount defines which entries are valid.

Verification
REQ-033 SHALL be checked by this scenario: rst for 2 cycles, then SEQ for 3 cycles -> currentAddress reads 0, 4, 8, 12 after successive edges.
REQ-034 SHALL be checked by this scenario: PC=0x100, BRANCH with offset=0xFFFFFFF0 -> PC=0xF0; then JUMP with target=0xFFFFFFFC, then SEQ -> PC=0xFFFFFFFC, then 0x00000000 (wrap).
REQ-035 SHALL be checked by this scenario: PC=0x40, CALL to 0x200, then CALL to 0x300, then RET, then RET -> PC reads 0x200, 0x300, 0x204, 0x44, and rasCount reads 1, 2, 1, 0.
REQ-036 SHALL be checked by this scenario: RAS_DEPTH=4, five CALLs, then five RETs -> rasOverflow=1 after the 5th CALL; the first four RETs return the four newest return addresses; the 5th RET sets rasUnderflow=1 and gives PC+INC.
REQ-037 SHALL be checked by this scenario: stall=1 for 3 cycles with mode=CALL -> PC, rasCount and flags unchanged; then rst=1 together with stall=1 -> PC=RESET_VECTOR and both flags cleared.
REQ-038 SHALL be checked by this scenario: JUMP to 0x102 -> misaligned=1 in the same cycle that PC=0x102; then SEQ -> PC=0x106 and misaligned stays 1.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/call/return next-address selection
// and a circular return-address stack that keeps the newest RAS_DEPTH entries.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [2:0]                     mode,
  input  logic [WIDTH-1:0]               target,
  input  logic [WIDTH-1:0]               offset,
  output logic [WIDTH-1:0]               currentAddress,
  output logic [$clog2(RAS_DEPTH+1)-1:0] rasCount,
  output logic                           rasOverflow,
  output logic                           rasUnderflow,
  output logic                           misaligned
);

  localparam int               PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [PW-1:0]    LAST_C  = PW'(RAS_DEPTH - 1);

  logic [WIDTH-1:0] pc_r, pc_nxt_s, seq_s;
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]    ptr_r, ptr_nxt_s, ptr_inc_s, ptr_dec_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             ovf_r, ovf_nxt_s, unf_r, unf_nxt_s, push_s;

  // ptr_r is the slot the next push writes; it wraps so a full stack overwrites its oldest entry
  assign seq_s     = pc_r + INC_W;
  assign ptr_inc_s = (ptr_r == LAST_C) ? {PW{1'b0}} : ptr_r + PW'(1);
  assign ptr_dec_s = (ptr_r == {PW{1'b0}}) ? LAST_C : ptr_r - PW'(1);

  // Next-address and stack bookkeeping selection
  always_comb begin
    pc_nxt_s  = pc_r;
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    push_s    = 1'b0;
    if (stall) begin
      pc_nxt_s  = pc_r;
      ptr_nxt_s = ptr_r;
      cnt_nxt_s = cnt_r;
    end else begin
      case (mode)
        3'd0: pc_nxt_s = seq_s;
        3'd1: pc_nxt_s = pc_r + offset;
        3'd2: pc_nxt_s = target;
        3'd3: begin
          push_s    = 1'b1;
          pc_nxt_s  = target;
          ptr_nxt_s = ptr_inc_s;
          if (cnt_r == DEPTH_C) begin
            ovf_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        3'd4: begin
          if (cnt_r != {CW{1'b0}}) begin
            pc_nxt_s  = ras_mem_r[ptr_dec_s];
            ptr_nxt_s = ptr_dec_s;
            cnt_nxt_s = cnt_r - CW'(1);
          end else begin
            pc_nxt_s  = seq_s;
            unf_nxt_s = 1'b1;
          end
        end
        default: pc_nxt_s = seq_s;
      endcase
    end
  end

  // PC, stack pointer, count and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= RESET_VECTOR;
      ptr_r <= {PW{1'b0}};
      cnt_r <= {CW{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      ptr_r <= ptr_nxt_s;
      cnt_r <= cnt_nxt_s;
      ovf_r <= ovf_nxt_s;
      unf_r <= unf_nxt_s;
    end
  end

  // Return-address storage; contents are meaningless after reset
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      ras_mem_r[ptr_r] <= seq_s;
    end
  end

  assign currentAddress = pc_r;
  assign rasCount       = cnt_r;
  assign rasOverflow    = ovf_r;
  assign rasUnderflow   = unf_r;
  assign misaligned     = |(pc_r & (INC_W - WIDTH'(1)));

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a queue-based model of the PC and return stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  mode;
  logic [31:0] target, offset;
  logic [31:0] currentAddress;
  logic [2:0]  rasCount;
  logic        rasOverflow, rasUnderflow, misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q [$];
  logic        m_ovf, m_unf;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .mode(mode), .target(target), .offset(offset),
    .currentAddress(currentAddress), .rasCount(rasCount), .rasOverflow(rasOverflow),
    .rasUnderflow(rasUnderflow), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge
  task automatic step(input logic r, input logic s, input logic [2:0] md,
                      input logic [31:0] tg, input logic [31:0] of);
    rst = r; stall = s; mode = md; target = tg; offset = of;
    if (r) begin
      m_pc = 32'h0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!s) begin
      case (md)
        3'd1: m_pc = m_pc + of;
        3'd2: m_pc = tg;
        3'd3: begin
          m_q.push_back(m_pc + 32'd4);
          if (m_q.size() > 4) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = tg;
        end
        3'd4: begin
          if (m_q.size() > 0) m_pc = m_q.pop_back();
          else begin
            m_pc = m_pc + 32'd4;
            m_unf = 1'b1;
          end
        end
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd3, 32'h500, 32'h0);
    step(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h0 || rasCount !== 3'd0 || rasOverflow !== 1'b0 || rasUnderflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pc=%h cnt=%0d ovf=%b unf=%b, want pc=0 cnt=0 ovf=0 unf=0",
               currentAddress, rasCount, rasOverflow, rasUnderflow);
    end
  endtask

  task automatic test_seq();
    logic [31:0] exp_v;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h1234);
      exp_v = 32'(4 * i);
      n_checks++;
      if (currentAddress !== exp_v) begin
        n_fail++;
        $display("FAIL seq[%0d]: pc=%h want %h", i, currentAddress, exp_v);
      end
    end
    step(1'b0, 1'b0, 3'd6, 32'h0, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h10) begin
      n_fail++;
      $display("FAIL mode6_as_seq: pc=%h want 00000010", currentAddress);
    end
  endtask

  task automatic test_branch_wrap();
    step(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h0, 32'hFFFF_FFF0);
    n_checks++;
    if (currentAddress !== 32'hF0) begin
      n_fail++;
      $display("FAIL branch_back: pc=%h want 000000f0", currentAddress);
    end
    step(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0);
    n_checks++;
    if (currentAddress !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL jump_top: pc=%h want fffffffc", currentAddress);
    end
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h0) begin
      n_fail++;
      $display("FAIL seq_wrap: pc=%h want 00000000", currentAddress);
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  md [4]  = '{3'd3, 3'd3, 3'd4, 3'd4};
    logic [31:0] tg [4]  = '{32'h200, 32'h300, 32'h0, 32'h0};
    logic [31:0] epc [4] = '{32'h200, 32'h300, 32'h204, 32'h44};
    logic [2:0]  ecnt [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 3'd2, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, md[i], tg[i], 32'h0);
      n_checks++;
      if (currentAddress !== epc[i] || rasCount !== ecnt[i]) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: pc=%h cnt=%0d want pc=%h cnt=%0d",
                 i, currentAddress, rasCount, epc[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_v;
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 3'd2, 32'h1000, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd3, 32'(32'h2000 + 32'h1000 * i), 32'h0);
    n_checks++;
    if (rasOverflow !== 1'b1 || rasCount !== 3'd4 || currentAddress !== 32'h6000) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b cnt=%0d pc=%h want ovf=1 cnt=4 pc=00006000",
               rasOverflow, rasCount, currentAddress);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'd4, 32'h0, 32'h0);
      exp_v = 32'(32'h5004 - 32'h1000 * i);
      n_checks++;
      if (currentAddress !== exp_v || rasCount !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL ovf_ret[%0d]: pc=%h cnt=%0d want pc=%h cnt=%0d",
                 i, currentAddress, rasCount, exp_v, 3 - i);
      end
    end
    step(1'b0, 1'b0, 3'd4, 32'h0, 32'h0);
    n_checks++;
    if (rasUnderflow !== 1'b1 || currentAddress !== 32'h2008 || rasCount !== 3'd0 || rasOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: unf=%b pc=%h cnt=%0d ovf=%b want unf=1 pc=00002008 cnt=0 ovf=1",
               rasUnderflow, currentAddress, rasCount, rasOverflow);
    end
  endtask

  task automatic test_stall_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd3, 32'h9000, 32'h0);
      n_checks++;
      if (currentAddress !== 32'h2008 || rasCount !== 3'd0 || rasOverflow !== 1'b1 || rasUnderflow !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: pc=%h cnt=%0d ovf=%b unf=%b want pc=00002008 cnt=0 ovf=1 unf=1",
                 i, currentAddress, rasCount, rasOverflow, rasUnderflow);
      end
    end
    step(1'b1, 1'b1, 3'd3, 32'h9000, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h0 || rasOverflow !== 1'b0 || rasUnderflow !== 1'b0 || rasCount !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_over_stall: pc=%h ovf=%b unf=%b cnt=%0d want pc=0 ovf=0 unf=0 cnt=0",
               currentAddress, rasOverflow, rasUnderflow, rasCount);
    end
  endtask

  task automatic test_misaligned();
    step(1'b0, 1'b0, 3'd2, 32'h102, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h102 || misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_jump: pc=%h mis=%b want pc=00000102 mis=1", currentAddress, misaligned);
    end
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if (currentAddress !== 32'h106 || misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_seq: pc=%h mis=%b want pc=00000106 mis=1", currentAddress, misaligned);
    end
    step(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned: mis=%b want 0", misaligned);
    end
  endtask

  task automatic test_random();
    logic        r, s;
    logic [2:0]  md;
    logic [31:0] tg, of;
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 7) == 0);
      md = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) md = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      of = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : (32'h0 - 32'($urandom_range(0, 255)));
      step(r, s, md, tg, of);
      n_checks++;
      if (currentAddress !== m_pc || rasCount !== 3'(m_q.size()) || rasOverflow !== m_ovf ||
          rasUnderflow !== m_unf || misaligned !== (m_pc[1:0] != 2'b00)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h cnt=%0d ovf=%b unf=%b mis=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 i, currentAddress, rasCount, rasOverflow, rasUnderflow, misaligned,
                 m_pc, m_q.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mode = 3'd0; target = 32'h0; offset = 32'h0;
    m_pc = 32'h0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    test_reset();
    test_seq();
    test_branch_wrap();
    test_call_ret();
    test_overflow();
    test_stall_reset();
    test_misaligned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
